// File: rtl/beehive_noc_hdr_tx_pkg.sv
// Shared NoC message widths, header flit layout and the data-header builder
// used by the NoC header packetizer.
package beehive_noc_hdr_tx_pkg;

  localparam int NOC_DATA_WIDTH       = 512;
  localparam int NOC_BYTES            = NOC_DATA_WIDTH / 8;
  localparam int NOC_BYTES_LOG2       = $clog2(NOC_BYTES);

  localparam int MSG_DST_CHIPID_WIDTH = 14;
  localparam int MSG_DST_X_WIDTH      = 8;
  localparam int MSG_DST_Y_WIDTH      = 8;
  localparam int MSG_DST_FBITS_WIDTH  = 4;
  localparam int MSG_LENGTH_WIDTH     = 22;
  localparam int MSG_TYPE_WIDTH       = 8;
  localparam int MSG_SRC_CHIPID_WIDTH = 14;
  localparam int MSG_SRC_X_WIDTH      = 8;
  localparam int MSG_SRC_Y_WIDTH      = 8;
  localparam int MSG_SRC_FBITS_WIDTH  = 4;
  localparam int MSG_METADATA_FLITS_W = 8;
  localparam int PACKET_NUM_W         = 16;
  localparam int TIMESTAMP_W          = 64;
  // Widest payload byte count a request can carry through the builder
  localparam int TX_REQ_BYTES_W       = 32;

  localparam logic [MSG_TYPE_WIDTH-1:0] IP_TX_DATAGRAM = 8'd20;

  typedef struct packed {
    logic [MSG_SRC_X_WIDTH-1:0] x_src;
    logic [MSG_SRC_Y_WIDTH-1:0] y_src;
  } noc_origin_struct;

  typedef struct packed {
    noc_origin_struct          origin;
    logic [PACKET_NUM_W-1:0]   packet_num;
  } packet_id_struct;

  typedef struct packed {
    logic [MSG_DST_CHIPID_WIDTH-1:0] dst_chip_id;
    logic [MSG_DST_X_WIDTH-1:0]      dst_x_coord;
    logic [MSG_DST_Y_WIDTH-1:0]      dst_y_coord;
    logic [MSG_DST_FBITS_WIDTH-1:0]  dst_fbits;
    logic [MSG_LENGTH_WIDTH-1:0]     msg_len;
    logic [MSG_TYPE_WIDTH-1:0]       msg_type;
    logic [MSG_SRC_CHIPID_WIDTH-1:0] src_chip_id;
    logic [MSG_SRC_X_WIDTH-1:0]      src_x_coord;
    logic [MSG_SRC_Y_WIDTH-1:0]      src_y_coord;
    logic [MSG_SRC_FBITS_WIDTH-1:0]  src_fbits;
    logic [MSG_METADATA_FLITS_W-1:0] metadata_flits;
    packet_id_struct                 packet_id;
    logic [TIMESTAMP_W-1:0]          timestamp;
  } data_noc_hdr_flit;

  localparam int DATA_NOC_HDR_W = $bits(data_noc_hdr_flit);

  typedef struct packed {
    data_noc_hdr_flit                         core;
    logic [NOC_DATA_WIDTH-DATA_NOC_HDR_W-1:0] padding;
  } beehive_noc_hdr_flit;

  typedef struct packed {
    logic [MSG_DST_X_WIDTH-1:0]      dst_x;
    logic [MSG_DST_Y_WIDTH-1:0]      dst_y;
    logic [MSG_DST_FBITS_WIDTH-1:0]  dst_fbits;
    logic [MSG_TYPE_WIDTH-1:0]       msg_type;
    logic [MSG_METADATA_FLITS_W-1:0] meta_flits;
    logic [TX_REQ_BYTES_W-1:0]       data_bytes;
  } tx_hdr_req_struct;

  typedef enum logic [1:0] {IDLE, HDR, META, DATA} hdr_tx_state_e;

  // Number of NOC-width flits needed to carry a payload (rounded up)
  function automatic logic [TX_REQ_BYTES_W:0] data_flits_of(input logic [TX_REQ_BYTES_W-1:0] bytes);
    return ({1'b0, bytes} + (TX_REQ_BYTES_W+1)'(NOC_BYTES - 1)) >> NOC_BYTES_LOG2;
  endfunction

  // Assemble a padded data header flit; unused chip ids, fbits and padding are zero
  function automatic beehive_noc_hdr_flit build_data_hdr(
    input tx_hdr_req_struct              req,
    input noc_origin_struct              origin,
    input logic [PACKET_NUM_W-1:0]       packet_num,
    input logic [TIMESTAMP_W-1:0]        ts
  );
    beehive_noc_hdr_flit flit;
    logic [TX_REQ_BYTES_W:0] flits;
    flit  = '0;
    flits = data_flits_of(req.data_bytes);
    flit.core.dst_x_coord          = req.dst_x;
    flit.core.dst_y_coord          = req.dst_y;
    flit.core.dst_fbits            = req.dst_fbits;
    flit.core.msg_len              = MSG_LENGTH_WIDTH'(flits + (TX_REQ_BYTES_W+1)'(req.meta_flits));
    flit.core.msg_type             = req.msg_type;
    flit.core.src_x_coord          = origin.x_src;
    flit.core.src_y_coord          = origin.y_src;
    flit.core.metadata_flits       = req.meta_flits;
    flit.core.packet_id.origin     = origin;
    flit.core.packet_id.packet_num = packet_num;
    flit.core.timestamp            = ts;
    return flit;
  endfunction

endpackage

// File: rtl/beehive_noc_hdr_tx.sv
// NoC packetizer: emits a data header flit, then passes caller metadata
// flits and payload flits through to the router port with no bubbles.
module beehive_noc_hdr_tx
  import beehive_noc_hdr_tx_pkg::*;
#(
  parameter int SRC_X        = 0,
  parameter int SRC_Y        = 0,
  parameter int DATA_BYTES_W = 16,
  parameter int NOC_W        = NOC_DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_val,
  output logic                            req_rdy,
  input  logic [MSG_DST_X_WIDTH-1:0]      req_dst_x,
  input  logic [MSG_DST_Y_WIDTH-1:0]      req_dst_y,
  input  logic [MSG_DST_FBITS_WIDTH-1:0]  req_dst_fbits,
  input  logic [MSG_TYPE_WIDTH-1:0]       req_msg_type,
  input  logic [MSG_METADATA_FLITS_W-1:0] req_meta_flits,
  input  logic [DATA_BYTES_W-1:0]         req_data_bytes,
  input  logic                            meta_val,
  input  logic [NOC_W-1:0]                meta_data,
  output logic                            meta_rdy,
  input  logic                            data_val,
  input  logic [NOC_W-1:0]                data_data,
  input  logic                            data_last,
  output logic                            data_rdy,
  output logic                            noc_out_val,
  output logic [NOC_W-1:0]                noc_out_data,
  input  logic                            noc_out_rdy,
  output logic                            len_err
);

  // Largest payload flit count; metadata plus payload must fit msg_len
  localparam longint MAX_DATA_FLITS =
    ((longint'(1) << DATA_BYTES_W) - 1 + longint'(NOC_BYTES) - 1) / longint'(NOC_BYTES);

  if (NOC_W != NOC_DATA_WIDTH || DATA_BYTES_W > TX_REQ_BYTES_W ||
      (255 + MAX_DATA_FLITS) >= (longint'(1) << MSG_LENGTH_WIDTH)) begin : g_cfg_err
    $error("beehive_noc_hdr_tx: msg_len or flit width cannot hold this configuration");
  end

  localparam noc_origin_struct ORIGIN = '{x_src: MSG_SRC_X_WIDTH'(SRC_X),
                                          y_src: MSG_SRC_Y_WIDTH'(SRC_Y)};

  hdr_tx_state_e                   state_reg, state_next;
  beehive_noc_hdr_flit             hdr_reg;
  logic [MSG_METADATA_FLITS_W-1:0] meta_cnt_reg;
  logic [DATA_BYTES_W:0]           data_cnt_reg;
  logic [PACKET_NUM_W-1:0]         packet_num_reg;
  logic [TIMESTAMP_W-1:0]          ts_reg;
  logic                            ready_reg;
  tx_hdr_req_struct                req_s;
  logic [DATA_BYTES_W:0]           req_data_flits;
  logic                            req_fire, meta_fire, data_fire, data_final;

  assign req_s.dst_x      = req_dst_x;
  assign req_s.dst_y      = req_dst_y;
  assign req_s.dst_fbits  = req_dst_fbits;
  assign req_s.msg_type   = req_msg_type;
  assign req_s.meta_flits = req_meta_flits;
  assign req_s.data_bytes = TX_REQ_BYTES_W'(req_data_bytes);

  assign req_data_flits = (DATA_BYTES_W+1)'(data_flits_of(req_s.data_bytes));
  assign req_fire       = req_val && req_rdy;
  assign meta_fire      = meta_val && meta_rdy;
  assign data_fire      = data_val && data_rdy;
  assign data_final     = (data_cnt_reg == (DATA_BYTES_W+1)'(1));

  // Free-running timestamp and the "out of reset" flag that opens req_rdy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_reg    <= '0;
      ready_reg <= 1'b0;
    end else begin
      ts_reg    <= ts_reg + 1'b1;
      ready_reg <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Latch header and flit counts on accept; count down per forwarded flit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_reg        <= '0;
      meta_cnt_reg   <= '0;
      data_cnt_reg   <= '0;
      packet_num_reg <= '0;
    end else begin
      if (req_fire) begin
        hdr_reg        <= build_data_hdr(req_s, ORIGIN, packet_num_reg, ts_reg);
        meta_cnt_reg   <= req_meta_flits;
        data_cnt_reg   <= req_data_flits;
        packet_num_reg <= packet_num_reg + 1'b1;
      end
      if (meta_fire) meta_cnt_reg <= meta_cnt_reg - 1'b1;
      if (data_fire) data_cnt_reg <= data_cnt_reg - 1'b1;
    end
  end

  // Next state, output mux and stream handshakes; count decides packet end
  always_comb begin
    state_next   = state_reg;
    req_rdy      = 1'b0;
    noc_out_val  = 1'b0;
    noc_out_data = hdr_reg;
    meta_rdy     = 1'b0;
    data_rdy     = 1'b0;
    len_err      = 1'b0;
    case (state_reg)
      IDLE: begin
        req_rdy = ready_reg;
        if (req_val && ready_reg) state_next = HDR;
      end
      HDR: begin
        noc_out_val = 1'b1;
        if (noc_out_rdy) begin
          if (meta_cnt_reg != '0)      state_next = META;
          else if (data_cnt_reg != '0) state_next = DATA;
          else                         state_next = IDLE;
        end
      end
      META: begin
        noc_out_val  = meta_val;
        noc_out_data = meta_data;
        meta_rdy     = noc_out_rdy;
        if (meta_val && noc_out_rdy && meta_cnt_reg == MSG_METADATA_FLITS_W'(1))
          state_next = (data_cnt_reg != '0) ? DATA : IDLE;
      end
      DATA: begin
        noc_out_val  = data_val;
        noc_out_data = data_data;
        data_rdy     = noc_out_rdy;
        if (data_val && noc_out_rdy) begin
          len_err = (data_last != data_final);
          if (data_final) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_beehive_noc_hdr_tx.sv
// Randomized self-checking bench for beehive_noc_hdr_tx: each packet is
// modelled as an expected queue of flits (header, metadata, payload).
module tb_beehive_noc_hdr_tx;
  import beehive_noc_hdr_tx_pkg::*;

  localparam int SX = 3;
  localparam int SY = 5;
  localparam int NB = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_val = 1'b0, req_rdy;
  logic [7:0] req_dst_x = '0, req_dst_y = '0, req_msg_type = '0, req_meta_flits = '0;
  logic [3:0] req_dst_fbits = '0;
  logic [15:0] req_data_bytes = '0;
  logic meta_val = 1'b0, meta_rdy, data_val = 1'b0, data_last = 1'b0, data_rdy;
  logic [511:0] meta_data = '0, data_data = '0, noc_out_data;
  logic noc_out_val, noc_out_rdy = 1'b0, len_err;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_pkt_num = '0;
  logic [63:0] cyc;

  beehive_noc_hdr_tx #(.SRC_X(SX), .SRC_Y(SY), .DATA_BYTES_W(16), .NOC_W(512)) dut (
    .clk(clk), .rst_n(rst_n), .req_val(req_val), .req_rdy(req_rdy),
    .req_dst_x(req_dst_x), .req_dst_y(req_dst_y), .req_dst_fbits(req_dst_fbits),
    .req_msg_type(req_msg_type), .req_meta_flits(req_meta_flits),
    .req_data_bytes(req_data_bytes), .meta_val(meta_val), .meta_data(meta_data),
    .meta_rdy(meta_rdy), .data_val(data_val), .data_data(data_data),
    .data_last(data_last), .data_rdy(data_rdy), .noc_out_val(noc_out_val),
    .noc_out_data(noc_out_data), .noc_out_rdy(noc_out_rdy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  // Cycles elapsed since reset release: the value the header should stamp
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [511:0] rand_flit();
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  // Drive one request and follow the packet flit by flit. Starts at a negedge
  // with the DUT idle; leaves when stop_left flits remain, at a negedge.
  task automatic run_packet(input int dx, input int dy, input int fb, input int mt,
                            input int meta_n, input int bytes, input int rdy_pct,
                            input int src_pct, input int bad_idx, input int stop_left,
                            output logic [63:0] ts_seen, output int cycles);
    logic [511:0] q[$];
    int kind[$];
    logic [511:0] mfl[$], dfl[$];
    int mi, di, nd, waited, k;
    bit mv, dv, exp_val, exp_err, prev_stall;
    logic [511:0] prev_data;
    beehive_noc_hdr_flit h, obs;
    logic [63:0] exp_ts;
    mi = 0; di = 0; mv = 0; dv = 0; prev_stall = 0; prev_data = '0;
    ts_seen = '0; cycles = 0;
    nd = (bytes + NB - 1) / NB;
    meta_val = 1'b0; data_val = 1'b0; noc_out_rdy = 1'b0;
    req_dst_x = 8'(dx); req_dst_y = 8'(dy); req_dst_fbits = 4'(fb);
    req_msg_type = 8'(mt); req_meta_flits = 8'(meta_n); req_data_bytes = 16'(bytes);
    req_val = 1'b1;
    #1;
    waited = 0;
    while (!req_rdy && waited < 50) begin
      @(negedge clk); #1; waited++;
    end
    checks++;
    if (!req_rdy) begin
      $display("FAIL req_accept_timeout req_rdy=%0b required=1", req_rdy);
      errors++;
      req_val = 1'b0;
      return;
    end
    exp_ts = cyc;
    @(negedge clk);
    req_val = 1'b0;
    h = '0;
    h.core.dst_x_coord = 8'(dx);
    h.core.dst_y_coord = 8'(dy);
    h.core.dst_fbits = 4'(fb);
    h.core.msg_len = 22'(meta_n + nd);
    h.core.msg_type = 8'(mt);
    h.core.src_x_coord = 8'(SX);
    h.core.src_y_coord = 8'(SY);
    h.core.metadata_flits = 8'(meta_n);
    h.core.packet_id.origin.x_src = 8'(SX);
    h.core.packet_id.origin.y_src = 8'(SY);
    h.core.packet_id.packet_num = exp_pkt_num;
    h.core.timestamp = exp_ts;
    exp_pkt_num = exp_pkt_num + 16'd1;
    q.push_back(h); kind.push_back(0);
    for (int i = 0; i < meta_n; i++) begin
      mfl.push_back(rand_flit()); q.push_back(mfl[i]); kind.push_back(1);
    end
    for (int i = 0; i < nd; i++) begin
      dfl.push_back(rand_flit()); q.push_back(dfl[i]); kind.push_back(2);
    end
    while (q.size() > stop_left && cycles < 4000) begin
      noc_out_rdy = ($urandom_range(99) < rdy_pct);
      if (!mv && mi < meta_n) mv = ($urandom_range(99) < src_pct);
      if (!dv && di < nd)     dv = ($urandom_range(99) < src_pct);
      meta_val = mv;
      meta_data = (mi < meta_n) ? mfl[mi] : rand_flit();
      data_val = dv;
      data_data = (di < nd) ? dfl[di] : rand_flit();
      data_last = (di == nd - 1) ^ (di == bad_idx);
      #1;
      k = kind[0];
      exp_val = (k == 0) ? 1'b1 : (k == 1) ? mv : dv;
      checks++;
      if (noc_out_val !== exp_val) begin
        $display("FAIL out_val flit_kind=%0d got=%0b required=%0b", k, noc_out_val, exp_val);
        errors++;
      end
      if (exp_val) begin
        checks++;
        if (noc_out_data !== q[0]) begin
          $display("FAIL out_data flit_kind=%0d got=%h required=%h", k, noc_out_data, q[0]);
          errors++;
        end
      end
      if (prev_stall) begin
        checks++;
        if (noc_out_val !== 1'b1 || noc_out_data !== prev_data) begin
          $display("FAIL stall_hold val=%0b got=%h required=%h", noc_out_val, noc_out_data, prev_data);
          errors++;
        end
      end
      checks++;
      if (meta_rdy !== (k == 1 && noc_out_rdy) || data_rdy !== (k == 2 && noc_out_rdy) || req_rdy !== 1'b0) begin
        $display("FAIL in_rdy meta_rdy=%0b data_rdy=%0b req_rdy=%0b required=%0b/%0b/0",
                 meta_rdy, data_rdy, req_rdy, (k == 1 && noc_out_rdy), (k == 2 && noc_out_rdy));
        errors++;
      end
      exp_err = (k == 2) && dv && noc_out_rdy && (data_last != (di == nd - 1));
      checks++;
      if (len_err !== exp_err) begin
        $display("FAIL len_err data_idx=%0d got=%0b required=%0b", di, len_err, exp_err);
        errors++;
      end
      if (k == 0) begin
        obs = noc_out_data;
        ts_seen = obs.core.timestamp;
      end
      prev_stall = exp_val && !noc_out_rdy;
      prev_data = q[0];
      if (exp_val && noc_out_rdy) begin
        void'(q.pop_front()); void'(kind.pop_front());
        if (k == 1) begin mi++; mv = 0; end
        if (k == 2) begin di++; dv = 0; end
      end
      cycles++;
      @(negedge clk);
    end
    meta_val = 1'b0; data_val = 1'b0; data_last = 1'b0; noc_out_rdy = 1'b0;
    checks++;
    if (q.size() > stop_left) begin
      $display("FAIL packet_timeout flits_left=%0d required=%0d", q.size(), stop_left);
      errors++;
    end else if (stop_left == 0) begin
      #1;
      checks++;
      if (req_rdy !== 1'b1 || noc_out_val !== 1'b0) begin
        $display("FAIL back_to_idle req_rdy=%0b out_val=%0b required=1/0", req_rdy, noc_out_val);
        errors++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (req_rdy !== 1'b0 || noc_out_val !== 1'b0 || meta_rdy !== 1'b0 || data_rdy !== 1'b0 || len_err !== 1'b0) begin
      $display("FAIL reset_outputs req_rdy=%0b val=%0b meta_rdy=%0b data_rdy=%0b len_err=%0b required=all0",
               req_rdy, noc_out_val, meta_rdy, data_rdy, len_err);
      errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_pkt_num = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (req_rdy !== 1'b1 || noc_out_val !== 1'b0) begin
      $display("FAIL post_reset_idle req_rdy=%0b val=%0b required=1/0", req_rdy, noc_out_val);
      errors++;
    end
  endtask

  task automatic test_basic();
    logic [63:0] ts; int cyc_used;
    run_packet(2, 1, 0, IP_TX_DATAGRAM, 1, 100, 100, 100, -1, 0, ts, cyc_used);
    checks++;
    if (cyc_used != 4) begin
      $display("FAIL basic_flit_cycles got=%0d required=4", cyc_used);
      errors++;
    end
    $display("basic packet: meta=1 bytes=100 cycles=%0d", cyc_used);
  endtask

  task automatic test_empty();
    logic [63:0] ts; int cyc_used;
    run_packet(7, 4, 3, 9, 0, 0, 100, 100, -1, 0, ts, cyc_used);
    checks++;
    if (cyc_used != 1) begin
      $display("FAIL empty_cycles got=%0d required=1", cyc_used);
      errors++;
    end
    $display("empty packet: header only cycles=%0d", cyc_used);
  endtask

  task automatic test_back_to_back();
    logic [63:0] ts1, ts2, ts3; int c1, c2, c3;
    run_packet(1, 1, 0, 5, 0, 0, 100, 100, -1, 0, ts1, c1);
    run_packet(1, 2, 0, 5, 1, 64, 100, 100, -1, 0, ts2, c2);
    run_packet(2, 2, 0, 5, 0, 0, 100, 100, -1, 0, ts3, c3);
    checks++;
    if (ts2 - ts1 != 64'd2) begin
      $display("FAIL b2b_ts_gap1 got=%0d required=2", ts2 - ts1);
      errors++;
    end
    checks++;
    if (ts3 - ts2 != 64'd4) begin
      $display("FAIL b2b_ts_gap2 got=%0d required=4", ts3 - ts2);
      errors++;
    end
    $display("back-to-back: ts gaps %0d %0d", ts2 - ts1, ts3 - ts2);
  endtask

  task automatic test_backpressure();
    logic [63:0] ts; int c;
    run_packet(4, 6, 1, 11, 0, 64, 50, 100, -1, 0, ts, c);
    $display("backpressure: bytes=64 cycles=%0d", c);
    for (int p = 0; p < 6; p++) begin
      int mn, by;
      mn = $urandom_range(3);
      by = $urandom_range(300);
      run_packet($urandom_range(255), $urandom_range(255), $urandom_range(15),
                 $urandom_range(255), mn, by, 50, 70, -1, 0, ts, c);
      $display("random packet %0d: meta=%0d bytes=%0d cycles=%0d", p, mn, by, c);
    end
  endtask

  task automatic test_len_err();
    logic [63:0] ts; int c;
    run_packet(3, 3, 0, 2, 0, 128, 100, 100, 0, 0, ts, c);
    checks++;
    if (c != 3) begin
      $display("FAIL len_err_flits cycles=%0d required=3", c);
      errors++;
    end
    run_packet(3, 3, 0, 2, 1, 200, 60, 80, 3, 0, ts, c);
    $display("length error packets done");
  endtask

  task automatic test_reset_mid_data();
    logic [63:0] ts; int c;
    run_packet(5, 5, 0, 1, 0, 128, 100, 100, -1, 1, ts, c);
    data_val = 1'b1; data_data = rand_flit(); noc_out_rdy = 1'b1;
    #1;
    checks++;
    if (noc_out_val !== 1'b1) begin
      $display("FAIL pre_reset_active val=%0b required=1", noc_out_val);
      errors++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (noc_out_val !== 1'b0 || data_rdy !== 1'b0 || req_rdy !== 1'b0) begin
      $display("FAIL reset_abort val=%0b data_rdy=%0b req_rdy=%0b required=0/0/0", noc_out_val, data_rdy, req_rdy);
      errors++;
    end
    @(negedge clk);
    data_val = 1'b0; noc_out_rdy = 1'b0;
    rst_n = 1'b1;
    exp_pkt_num = '0;
    repeat (2) @(negedge clk);
    run_packet(6, 6, 0, 1, 0, 10, 100, 100, -1, 0, ts, c);
    $display("reset mid-data: restarted packet_num=0");
  endtask

  task automatic test_pkt_wrap();
    logic [63:0] ts; int c;
    force dut.packet_num_reg = 16'hFFFF;
    #1;
    release dut.packet_num_reg;
    exp_pkt_num = 16'hFFFF;
    run_packet(1, 0, 0, 4, 0, 0, 100, 100, -1, 0, ts, c);
    run_packet(1, 0, 0, 4, 0, 0, 100, 100, -1, 0, ts, c);
    $display("packet_num wrap: 0xffff then 0x0000");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_back_to_back();
    test_backpressure();
    test_len_err();
    test_reset_mid_data();
    test_pkt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/beehive_noc_hdr_tx.md
Name: beehive_noc_hdr_tx

Overview:
Packetizer that sits directly upstream of the NoC router port. It builds a data_noc_hdr_flit (padded to NOC width as beehive_noc_hdr_flit), then streams caller-supplied metadata flits and payload flits behind it. It stamps msg_len, the packet_id (origin + running packet_num) and a 64-bit timestamp. Used by any tile that originates NoC data messages (eth rx, ip/tcp/udp tx, tracker).

Parameters:
SRC_X, 0, this tile's x coord (header src_x_coord and packet_id.origin.x_src)
SRC_Y, 0, this tile's y coord (src_y_coord and origin.y_src)
DATA_BYTES_W, 16, width of payload byte-count field
NOC_W, `NOC_DATA_WIDTH, flit width in bits; NOC_BYTES = NOC_W/8

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_val  in  1  message request valid
req_rdy  out  1  request accepted when req_val&&req_rdy
req_dst_x  in  `MSG_DST_X_WIDTH  destination x
req_dst_y  in  `MSG_DST_Y_WIDTH  destination y
req_dst_fbits  in  `MSG_DST_FBITS_WIDTH  destination fbits
req_msg_type  in  `MSG_TYPE_WIDTH  e.g. IP_TX_DATAGRAM
req_meta_flits  in  MSG_METADATA_FLITS_W  number of metadata flits (0..255)
req_data_bytes  in  DATA_BYTES_W  payload bytes (0 allowed)
meta_val / meta_data / meta_rdy  in/in/out  1/NOC_W/1  metadata flit stream
data_val / data_data / data_last / data_rdy  in/in/in/out  1/NOC_W/1/1  payload flit stream
noc_out_val / noc_out_data / noc_out_rdy  out/out/in  1/NOC_W/1  to router
len_err  out  1  one-cycle pulse on payload length mismatch

Behaviour:
- Reset: req_rdy=0 during reset, 1 in IDLE afterwards; noc_out_val=0, meta_rdy=0, data_rdy=0, len_err=0, packet_num=0, timestamp counter=0, state=IDLE. Reset mid-packet aborts the packet; router sees no further flits.
- Timestamp counter: 64-bit, increments every cycle, wraps at 2^64-1 -> 0.
- data_flits = ceil(req_data_bytes/NOC_BYTES) (0 when bytes=0). msg_len = req_meta_flits + data_flits, computed at DATA_BYTES_W+1 bits then truncated to `MSG_LENGTH_WIDTH`. An elaboration assertion checks 255 + max data_flits fits.
- Header fields: dst_chip_id=0, src_chip_id=0, src_fbits=0, metadata_flits=req_meta_flits, packet_id={SRC_X,SRC_Y,packet_num}, timestamp=counter value in the accept cycle, padding=0.
- States:
  - IDLE: req_rdy=1. On accept, register header, meta count and data count, then go to HDR. packet_num increments with wrap to 0 at all-ones (PACKET_NUM_W bits).
  - HDR: noc_out_val=1, data=registered header. On noc_out_rdy, go to META if meta>0, else DATA if data>0, else IDLE.
  - META: noc_out_val=meta_val, meta_rdy=noc_out_rdy, pass-through with no bubble. Decrement on each handshake. When the last one is sent, go to DATA or IDLE.
  - DATA: noc_out_val=data_val, data_rdy=noc_out_rdy, pass-through. Decrement per handshake. On the final flit, go to IDLE.
- Latency: 1 cycle from req accept to header valid. After that, 1 flit/cycle when the router is ready. A back-to-back request is accepted in the cycle after the last flit, so there is one idle cycle between packets.
- Header is held stable while noc_out_rdy=0. Outputs stay stable under backpressure; only the input handshake is combinational.
- Length check:
  - If data_last=1 on a non-final data flit, or data_last=0 on the final one, len_err pulses in that handshake cycle.
  - The flit is still forwarded, and the count (not data_last) ends the packet.
- meta_rdy and data_rdy are 0 outside their respective states.

Decomposition:
- Add to beehive_noc_msg:
  - tx_hdr_req_struct (dst x/y/fbits, msg_type, meta_flits, data_bytes).
  - Enum hdr_tx_state_e {IDLE,HDR,META,DATA}.
  - Function build_data_hdr(req, origin, packet_num, ts) returning beehive_noc_hdr_flit.
- No sub-module. Counters and the FSM live in one file.

Test Plan:
- Request dst (2,1), type IP_TX_DATAGRAM, meta=1, bytes=100, NOC_BYTES=64, router always ready -> header at accept+1 with msg_len=3 and metadata_flits=1, then 1 meta flit and 2 data flits on consecutive cycles, data_last on flit 2, no len_err.
- Request meta=0, bytes=0 -> single header flit, msg_len=0, back to IDLE; meta_rdy and data_rdy never asserted.
- Two back-to-back requests -> packet_num 0 then 1; timestamps differ by exactly the cycles between the two accepts; origin={SRC_X,SRC_Y}.
- Toggle noc_out_rdy randomly 50% with bytes=64 -> header and flits held stable while stalled; exactly 1 data flit; flit order preserved.
- bytes=128 with data_last set on the first data flit -> len_err pulses once and 2 data flits are still sent. Reset asserted mid-DATA -> noc_out_val=0 immediately, state IDLE, packet_num=0.
- Force packet_num to all-ones and send a packet -> next packet_num=0.
